// File: rtl/fetch_stage_if.sv
//------------------------------------------------------------------------------
// fetch_stage_if
// Fetch-stage bus bundle: I-cache read/resp, redirect input, IF/ID output.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface fetch_stage_if;
    logic [31:0] imem_address;
    logic        imem_read;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic [31:0] if_next_pc;

    modport master (
        output imem_address, imem_read,
        input  imem_rdata, imem_resp,
        input  redirect, redirect_pc, id_ready,
        output if_valid, if_pc, if_inst, if_next_pc
    );

    modport slave (
        input  imem_address, imem_read,
        output imem_rdata, imem_resp,
        output redirect, redirect_pc, id_ready,
        input  if_valid, if_pc, if_inst, if_next_pc
    );
endinterface

`default_nettype wire

// File: rtl/fetch_stage.sv
//------------------------------------------------------------------------------
// fetch_stage
// Owns the PC, fetches from the I-cache and hands PC/inst/next-PC to IF/ID.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
    input  wire          clk,
    input  wire          rst,
    fetch_stage_if.master bus
);

    localparam logic [1:0] ST_REQ    = 2'd0;
    localparam logic [1:0] ST_HOLD   = 2'd1;
    localparam logic [1:0] ST_SQUASH = 2'd2;

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [31:0] pc;
    logic [31:0] pc_nxt;
    logic [31:0] hold_inst;
    logic [31:0] hold_inst_nxt;
    logic [31:0] pending_pc;
    logic [31:0] pending_pc_nxt;

    logic [31:0] pc_plus4;
    logic [31:0] redirect_tgt;
    logic        read;
    logic        valid;
    logic [31:0] inst;

    assign pc_plus4     = pc + 32'd4;
    assign redirect_tgt = {bus.redirect_pc[31:2], 2'b00};

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        hold_inst_nxt  = hold_inst;
        pending_pc_nxt = pending_pc;
        read           = 1'b0;
        valid          = 1'b0;
        inst           = 32'd0;

        case (state)
            ST_REQ: begin
                read = 1'b1;
                if (bus.imem_resp) begin
                    if (bus.redirect) begin
                        pc_nxt = redirect_tgt;
                    end else begin
                        // Offer the word straight from the cache this cycle.
                        valid = 1'b1;
                        inst  = bus.imem_rdata;
                        if (bus.id_ready) begin
                            pc_nxt = pc_plus4;
                        end else begin
                            hold_inst_nxt = bus.imem_rdata;
                            state_nxt     = ST_HOLD;
                        end
                    end
                end else if (bus.redirect) begin
                    // Request in flight: keep the address, remember the target.
                    pending_pc_nxt = redirect_tgt;
                    state_nxt      = ST_SQUASH;
                end
            end

            ST_HOLD: begin
                if (bus.redirect) begin
                    pc_nxt    = redirect_tgt;
                    state_nxt = ST_REQ;
                end else begin
                    valid = 1'b1;
                    inst  = hold_inst;
                    if (bus.id_ready) begin
                        pc_nxt    = pc_plus4;
                        state_nxt = ST_REQ;
                    end
                end
            end

            ST_SQUASH: begin
                read = 1'b1;
                if (bus.redirect) begin
                    pending_pc_nxt = redirect_tgt;
                end
                if (bus.imem_resp) begin
                    pc_nxt    = bus.redirect ? redirect_tgt : pending_pc;
                    state_nxt = ST_REQ;
                end
            end

            default: begin
                state_nxt = ST_REQ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_REQ;
            pc         <= RESET_PC;
            hold_inst  <= 32'd0;
            pending_pc <= 32'd0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            hold_inst  <= hold_inst_nxt;
            pending_pc <= pending_pc_nxt;
        end
    end

    // Outputs are forced to a bubble while reset is held.
    assign bus.imem_address = pc;
    assign bus.imem_read    = read & ~rst;
    assign bus.if_valid     = valid & ~rst;
    assign bus.if_pc        = (valid & ~rst) ? pc       : 32'd0;
    assign bus.if_inst      = (valid & ~rst) ? inst     : 32'd0;
    assign bus.if_next_pc   = (valid & ~rst) ? pc_plus4 : 32'd0;

    a_req_stable: assert property (
        @(posedge clk) disable iff (rst)
        (bus.imem_read && !bus.imem_resp) |=> (bus.imem_read && $stable(bus.imem_address))
    );

    a_hold_no_read: assert property (
        @(posedge clk) disable iff (rst)
        (state == ST_HOLD) |-> !bus.imem_read
    );

endmodule

`default_nettype wire
